// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS mult/multu/div/divu sequencer: 32-step shift-add multiply or restoring divide,
// one sign fix-up cycle, then HI/LO/zon commit. Optional divide-by-zero flag via MULDIV_DIVZERO_EN.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] gr1,
    input  logic [XLEN-1:0] gr2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [2:0]      zon
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic            dz
`endif
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Latched operation attributes
    logic is_div;
    logic is_signed;
    logic sa;
    logic sb;
    logic div_ovf;
`ifdef MULDIV_DIVZERO_EN
    logic dz_pend;
`endif

    // Shared datapath: acc = product high half / remainder, low = multiplier / quotient,
    // opb = multiplicand / divisor.
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] opb;

    // Operand preparation at accept
    logic            req_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    // Iteration step
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_sub;
    logic            div_ge;
    logic [XLEN:0]   rem_nxt;

    // Sign fix-up and flags
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;
    logic [2:0]        res_zon;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(XLEN - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = ~req_ready;
    assign accept = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Operand preparation and per-step arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        req_signed = ~op[0];
        a_neg      = req_signed & gr1[XLEN-1];
        b_neg      = req_signed & gr2[XLEN-1];
        mag_a      = a_neg ? -gr1 : gr1;
        mag_b      = b_neg ? -gr2 : gr2;

        mul_sum    = low[0] ? (acc + {1'b0, opb}) : acc;

        // Remainder stays below the divisor, so the top bit of rem_nxt is always zero.
        div_shift  = {acc[XLEN-1:0], low[XLEN-1]};
        div_sub    = div_shift - {1'b0, opb};
        div_ge     = (div_shift >= {1'b0, opb});
        rem_nxt    = div_ge ? div_sub : div_shift;
    end

    always_comb begin
        product  = {acc[XLEN-1:0], low};
        prod_fix = (sa ^ sb) ? -product : product;
        quo_fix  = (sa ^ sb) ? -low : low;
        rem_fix  = sa ? -acc[XLEN-1:0] : acc[XLEN-1:0];

        if (is_div) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[2*XLEN-1:XLEN];
            res_lo = prod_fix[XLEN-1:0];
        end

        res_zon[2] = ({res_hi, res_lo} == '0);
        if (is_div) begin
            res_zon[1] = div_ovf;
            res_zon[0] = res_lo[XLEN-1];
        end else begin
            res_zon[1] = is_signed ? (res_hi != {XLEN{res_lo[XLEN-1]}}) : (res_hi != '0);
            res_zon[0] = res_hi[XLEN-1];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: working registers are always loaded at accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div    <= op[1];
            is_signed <= req_signed;
            sa        <= a_neg;
            sb        <= b_neg;
            div_ovf   <= (op == 2'b10) && (gr1 == {1'b1, {(XLEN-1){1'b0}}}) && (gr2 == '1);
`ifdef MULDIV_DIVZERO_EN
            dz_pend   <= op[1] && (gr2 == '0);
`endif
            acc       <= '0;
            low       <= op[1] ? mag_a : mag_b;
            opb       <= op[1] ? mag_b : mag_a;
        end else if (state == RUN) begin
            if (is_div) begin
                acc <= rem_nxt;
                low <= {low[XLEN-2:0], div_ge};
            end else begin
                acc <= {1'b0, mul_sum[XLEN:1]};
                low <= {mul_sum[0], low[XLEN-1:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter, results, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            zon  <= '0;
`ifdef MULDIV_DIVZERO_EN
            dz   <= 1'b0;
`endif
        end else begin
            done <= (state == FIX);

            if (accept) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
            end

`ifdef MULDIV_DIVZERO_EN
            if (accept) begin
                dz <= 1'b0;
            end
            if (state == FIX) begin
                if (dz_pend) begin
                    zon <= '0;
                    dz  <= 1'b1;
                end else begin
                    hi  <= res_hi;
                    lo  <= res_lo;
                    zon <= res_zon;
                end
            end
`else
            if (state == FIX) begin
                hi  <= res_hi;
                lo  <= res_lo;
                zon <= res_zon;
            end
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: randomized requests checked against a 64-bit arithmetic model.
// Honours MULDIV_DIVZERO_EN when the design is built with it.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [31:0] gr1;
    logic [31:0] gr2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  zon;
`ifdef MULDIV_DIVZERO_EN
    logic        dz;
`endif

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .gr1       (gr1),
        .gr2       (gr2),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .zon       (zon)
`ifdef MULDIV_DIVZERO_EN
        ,
        .dz        (dz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [2:0]  zon;
        logic        dz;
        int          acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passed = 0;
    int          cyc    = 0;
    int          dones  = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural meaning of each op.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        logic        ovf;
        e.dz = 1'b0;
        e.acc_cyc = 0;
        ovf = 1'b0;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32];
                e.lo = p[31:0];
                ovf  = (longint'(p) != longint'($signed(e.lo)));
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
                ovf  = (p > 64'h0000_0000_FFFF_FFFF);
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = (o == 2'b10 && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                    ovf  = (longint'(q) > 64'sd2147483647);
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
        endcase
        e.zon[2] = ({e.hi, e.lo} == 64'd0);
        e.zon[1] = ovf;
        e.zon[0] = o[1] ? e.lo[31] : e.hi[31];
`ifdef MULDIV_DIVZERO_EN
        if (o[1] && b == 32'd0) begin
            e.hi  = model_hi;
            e.lo  = model_lo;
            e.zon = 3'b000;
            e.dz  = 1'b1;
        end
`endif
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            dones++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("zon", zon, mon_e.zon);
                check("latency", cyc, mon_e.acc_cyc + 33);
                check("ready_in_done", {busy, req_ready}, 2'b01);
`ifdef MULDIV_DIVZERO_EN
                check("dz", dz, mon_e.dz);
`endif
            end
        end
    end

    localparam int N_DIR = 10;
    logic [1:0]  dir_op [N_DIR] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01};
    logic [31:0] dir_a  [N_DIR] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000,
                                    32'd0, 32'd5, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678};
    logic [31:0] dir_b  [N_DIR] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'hFFFF_FFFF,
                                    32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 32'h9ABC_DEF0};

    initial begin
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        int          w;
        int          dones_before;

        rst = 1'b1; req_valid = 1'b0; op = 2'b00; gr1 = '0; gr2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_zon", zon, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < N_DIR + 40; i++) begin
            if (i < N_DIR) begin
                o = dir_op[i]; a = dir_a[i]; b = dir_b[i];
            end else begin
                o = 2'($urandom_range(0, 3)); a = pick(); b = pick();
            end
            // While busy, keep req_valid high with junk operands: all of it must be ignored.
            req_valid = 1'b1;
            w = 0;
            while (!req_ready && w < 100) begin
                op = 2'($urandom); gr1 = $urandom; gr2 = $urandom;
                @(negedge clk);
                w++;
            end
            check("accept_wait", (w < 100), 1'b1);
            if (w >= 100) break;
            op = o; gr1 = a; gr2 = b;
            e = model(o, a, b);
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
            model_hi = e.hi;
            model_lo = e.lo;
            @(negedge clk);
            gr1 = $urandom; gr2 = $urandom; op = 2'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
        end
        req_valid = 1'b0;

        w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", sb_q.size(), 0);

        // Abort: reset during RUN step 10 must drop the op and clear hi/lo.
        op = 2'b01; gr1 = 32'hFFFF_0001; gr2 = 32'h0001_FFFF; req_valid = 1'b1;
        @(negedge clk);
        check("abort_accepted", busy, 1'b1);
        req_valid = 1'b0;
        dones_before = dones;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        check("abort_ready", req_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", dones, dones_before);

        // One more op after the abort to confirm recovery.
        op = 2'b00; gr1 = 32'hFFFF_FFFD; gr2 = 32'd5; req_valid = 1'b1;
        e = model(op, gr1, gr2);
        e.acc_cyc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (sb_q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("recover_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
